// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: turns per-stage stall/flush requests and a memory
// handshake into per-stage stall, flush and bubble controls, with stall/timeout stats.
module pipe_hazard_ctrl #(
  parameter int NSTAGE    = 5,
  parameter int MEM_STAGE = 3,
  parameter int TIMEOUT   = 16,
  parameter int CW        = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSTAGE-1:0] stall_req,
  input  logic [NSTAGE-1:0] flush_req,
  input  logic              mem_req,
  input  logic              mem_ack,
  input  logic              cnt_clr,
  output logic [NSTAGE-1:0] stall,
  output logic [NSTAGE-1:0] flush,
  output logic [NSTAGE-1:0] bubble,
  output logic              mem_busy,
  output logic              timeout_pulse,
  output logic              timeout_err,
  output logic [CW-1:0]     stall_cycles
);

  typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic [CW-1:0]     scnt_q, scnt_d;
  logic              err_q, err_d;
  logic              mem_wait;
  logic [NSTAGE-1:0] ustall;
  logic [NSTAGE-1:0] honoured;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + CW'(1);
  endfunction

  // Memory wait is suppressed while reset is held so the pipeline sees no stall.
  assign mem_wait = rst && (((state_q == IDLE) && mem_req && !mem_ack) || (state_q == WAIT));

  always_comb begin
    logic acc;
    acc    = 1'b0;
    ustall = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      acc       = acc | stall_req[j];
      ustall[j] = acc | (mem_wait && (j <= MEM_STAGE));
    end
  end

  // A flush request from a stage that is itself frozen is ignored this cycle.
  assign honoured = flush_req & ~ustall;

  always_comb begin
    logic facc;
    facc  = 1'b0;
    flush = '0;
    for (int j = NSTAGE - 1; j >= 0; j--) begin
      flush[j] = facc;
      facc     = facc | honoured[j];
    end
  end

  assign stall = ustall & ~flush;

  always_comb begin
    bubble = '0;
    for (int j = 1; j < NSTAGE; j++) begin
      bubble[j] = stall[j-1] & ~stall[j] & ~flush[j];
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    unique case (state_q)
      IDLE: begin
        wcnt_d = '0;
        if (mem_req && !mem_ack) begin
          state_d = WAIT;
          wcnt_d  = 8'd1;
        end
      end
      WAIT: begin
        // Ack wins over a timeout landing in the same cycle.
        if (mem_ack) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end else if (wcnt_q == WAIT_LAST) begin
          state_d = ERR;
          wcnt_d  = '0;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      ERR: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    scnt_d = scnt_q;
    err_d  = err_q;
    if (cnt_clr) begin
      scnt_d = '0;
      err_d  = 1'b0;
    end else begin
      if (stall[0]) scnt_d = sat_inc(scnt_q);
      if (state_d == ERR) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      scnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      scnt_q  <= scnt_d;
      err_q   <= err_d;
    end
  end

  assign mem_busy      = (state_q == WAIT);
  assign timeout_pulse = (state_q == ERR);
  assign timeout_err   = err_q;
  assign stall_cycles  = scnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: default instance plus a CW=4 instance
// sharing the same stimulus for counter saturation.
module tb_pipe_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] stall_req, flush_req;
  logic       mem_req, mem_ack, cnt_clr;

  logic [4:0]  stall, flush, bubble;
  logic        mem_busy, timeout_pulse, timeout_err;
  logic [31:0] stall_cycles;

  logic [4:0]  stall_b, flush_b, bubble_b;
  logic        mem_busy_b, timeout_pulse_b, timeout_err_b;
  logic [3:0]  stall_cycles_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
    .stall(stall), .flush(flush), .bubble(bubble), .mem_busy(mem_busy),
    .timeout_pulse(timeout_pulse), .timeout_err(timeout_err),
    .stall_cycles(stall_cycles)
  );

  pipe_hazard_ctrl #(.CW(4)) dut_cw4 (
    .clk(clk), .rst(rst), .stall_req(stall_req), .flush_req(flush_req),
    .mem_req(mem_req), .mem_ack(mem_ack), .cnt_clr(cnt_clr),
    .stall(stall_b), .flush(flush_b), .bubble(bubble_b), .mem_busy(mem_busy_b),
    .timeout_pulse(timeout_pulse_b), .timeout_err(timeout_err_b),
    .stall_cycles(stall_cycles_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_counters();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; stall_req = '0; flush_req = '0;
    mem_req = 1'b1; mem_ack = 1'b0; cnt_clr = 1'b0;
    repeat (3) tick();
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_mem_busy", mem_busy, 0);
    chk("rst_timeout_pulse", timeout_pulse, 0);
    chk("rst_memreq_no_stall", stall, 5'b00000);
    mem_req = 1'b0;
    rst = 1'b1;
    tick();

    // Younger-stage freeze from stage 3
    stall_req = 5'b01000;
    #1;
    chk("sreq3_stall", stall, 5'b01111);
    chk("sreq3_bubble", bubble, 5'b10000);
    chk("sreq3_flush", flush, 5'b00000);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("sreq3_cycles", stall_cycles, i);
    end
    stall_req = '0;
    clear_counters();
    chk("clr_cycles", stall_cycles, 0);

    // Flush honoured / blocked
    flush_req = 5'b00100;
    #1;
    chk("flush2_flush", flush, 5'b00011);
    chk("flush2_stall", stall, 5'b00000);
    chk("flush2_bubble", bubble, 5'b00000);
    stall_req = 5'b01000;
    #1;
    chk("flush2_blk_flush", flush, 5'b00000);
    chk("flush2_blk_stall", stall, 5'b01111);
    flush_req = 5'b10000; stall_req = 5'b00100;
    #1;
    chk("flush4_over_stall_flush", flush, 5'b01111);
    chk("flush4_over_stall_stall", stall, 5'b00000);
    chk("flush4_over_stall_bubble", bubble, 5'b00000);
    flush_req = '0; stall_req = '0;
    tick();
    clear_counters();

    // Memory wait acked after three wait cycles
    mem_req = 1'b1;
    #1;
    chk("mem_idle_stall", stall, 5'b01111);
    chk("mem_idle_bubble", bubble, 5'b10000);
    chk("mem_idle_busy", mem_busy, 0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      if (i == 3) begin
        mem_ack = 1'b1;
        #1;
      end
      chk("mem_wait_busy", mem_busy, 1);
      chk("mem_wait_stall", stall, 5'b01111);
    end
    tick();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("mem_done_busy", mem_busy, 0);
    chk("mem_done_stall", stall, 5'b00000);
    chk("mem_done_err", timeout_err, 0);
    chk("mem_done_cycles", stall_cycles, 4);
    clear_counters();

    // Timeout with no ack
    mem_req = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_wait_busy", mem_busy, 1);
      chk("to_wait_pulse", timeout_pulse, 0);
    end
    tick();
    chk("to_err_pulse", timeout_pulse, 1);
    chk("to_err_busy", mem_busy, 0);
    chk("to_err_flag", timeout_err, 1);
    chk("to_err_stall", stall, 5'b00000);
    mem_req = 1'b0;
    tick();
    chk("to_after_pulse", timeout_pulse, 0);
    chk("to_after_flag", timeout_err, 1);
    repeat (3) tick();
    chk("to_sticky_flag", timeout_err, 1);
    clear_counters();
    chk("to_clr_flag", timeout_err, 0);

    // Ack coincident with the last wait cycle
    mem_req = 1'b1;
    repeat (15) tick();
    mem_ack = 1'b1;
    #1;
    chk("ackedge_busy", mem_busy, 1);
    tick();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("ackedge_pulse", timeout_pulse, 0);
    chk("ackedge_busy_after", mem_busy, 0);
    chk("ackedge_err", timeout_err, 0);

    // Request and ack in the same cycle
    mem_req = 1'b1; mem_ack = 1'b1;
    #1;
    chk("reqack_stall", stall, 5'b00000);
    tick();
    mem_req = 1'b0; mem_ack = 1'b0;
    #1;
    chk("reqack_busy", mem_busy, 0);
    clear_counters();

    // Reset during a wait
    mem_req = 1'b1;
    repeat (3) tick();
    chk("rstwait_busy_before", mem_busy, 1);
    rst = 1'b0;
    #1;
    chk("rstwait_busy", mem_busy, 0);
    chk("rstwait_pulse", timeout_pulse, 0);
    chk("rstwait_cycles", stall_cycles, 0);
    chk("rstwait_stall", stall, 5'b00000);
    mem_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    chk("rstwait_rel_busy", mem_busy, 0);
    chk("rstwait_rel_pulse", timeout_pulse, 0);
    chk("rstwait_rel_err", timeout_err, 0);

    // Continuous stall: CW=4 instance saturates
    stall_req = 5'b00001;
    repeat (20) tick();
    chk("sat_cw32", stall_cycles, 20);
    chk("sat_cw4", stall_cycles_b, 15);
    tick();
    chk("sat_cw4_hold", stall_cycles_b, 15);
    stall_req = '0;
    clear_counters();
    chk("sat_cw4_clr", stall_cycles_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
